fpu_addsub_seq: RTL
===================

Name: fpu_addsub_seq

Overview:
- Multi-cycle sequencer for floating-point add/subtract. It owns the iterative exponent-alignment and normalization datapath and steps it through an FSM.
- Accepts one operand pair per valid/ready transaction and returns one truncated IEEE-style result through a valid/ready output handshake.
- Sits between the FPU operand issue logic and the result writeback.

Parameters:
- SIZE, 32, total word width.
- EXPONENT, 5 + ($clog2(SIZE)-4)*3, exponent width (8 for 32, 11 for 64).
- FRACTION, SIZE-EXPONENT-1, stored fraction width.
- BIAS, 2**(EXPONENT-1)-1, exponent bias (informational; no rebias needed).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  operand pair valid.
- o_ready  out  1  block can accept an operand pair (high only in IDLE).
- i_A  in  SIZE  operand A {sign, exp, frac}.
- i_B  in  SIZE  operand B.
- i_sub  in  1  1 computes A-B, 0 computes A+B.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  SIZE  result word.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, i_clk; reset is synchronous and active-high, i_rst. With i_rst high at a rising edge the block enters IDLE, o_valid=0, o_result=0, o_busy=0, o_ready=1. This applies in any state, mid-operation included; the in-flight operation is discarded.
- States: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE: an accept occurs when i_valid&o_ready is high at a rising edge. On accept, latch signs (B sign inverted if i_sub), exponents, and mantissas {1'b0, hidden, frac} of width FRACTION+2. The hidden bit is 0 when exp==0; exp==0 means zero, and denormals are flushed to zero.
- Special case: if either exponent is all-ones, go directly to DONE. o_result = A if A's exp is all-ones, else B with its sign inverted when i_sub.
- ALIGN: each cycle compare exponents.
  - Equal: go to ADD.
  - Otherwise, if the difference exceeds FRACTION+1, clear the smaller mantissa and copy the larger exponent in one cycle.
  - Otherwise, increment the smaller exponent and shift its mantissa right by 1 (shifted-out bits are dropped).
  - Stay in ALIGN until the exponents are equal.
  - s = number of modifying ALIGN cycles.
- ADD, one cycle:
  - Equal signs: add the mantissas; result sign is the common sign.
  - Unequal signs: subtract the smaller magnitude from the larger; result sign is that of the larger.
  - Equal magnitudes give +0.
- NORM: one check or shift per cycle.
  - Mantissa zero: result +0, go to DONE.
  - Carry bit set: shift right 1, exp+1. If exp becomes all-ones, result is ±infinity (frac=0) and go to DONE.
  - Hidden bit clear: shift left 1, exp-1. If exp reaches 0, result is ±0 (underflow flush) and go to DONE.
  - Otherwise normalized: go to DONE.
  - n = number of shifting NORM cycles.
- Result packing: o_result = {sign, exp, mantissa[FRACTION-1:0]}. Truncation only, no rounding.
- Latency: the accept edge enters ALIGN. DONE is entered 3+s+n rising edges after the accept edge; the special case enters DONE 1 edge after accept.
- DONE:
  - o_valid=1; o_result is stable while i_ready=0.
  - On o_valid&i_ready, go to IDLE with o_valid=0; o_result holds its value.
  - No new operand can be accepted in the same cycle as a result handshake; o_ready rises the following cycle.
- i_A, i_B and i_sub are ignored outside an IDLE accept.

Optional Feature:
- Macro FPU_SEQ_FAST_ALIGN_EN.
- Defined: ALIGN completes in exactly one cycle using a barrel shift of min(diff, FRACTION+2), so s=0 always.
- Undefined: one-bit-per-cycle alignment as described above.
- Results are identical in both builds; only latency differs.

Test Plan:
- A=0x3F800000, B=0x3F800000, sub=0 -> o_result=0x40000000; o_valid 4 cycles after accept (s=0, n=1).
- A=0x3F800000, B=0x3F000000, sub=0 -> 0x3FC00000; latency 4 (s=1, n=0); latency 3 with FPU_SEQ_FAST_ALIGN_EN.
- A=0x3FC00000, B=0x3FC00000, sub=1 -> 0x00000000 (+0); latency 3.
- A=0x3F800000, B=0x3F400000, sub=1 -> 0x3E800000; latency 6 (s=1, n=2).
- A=0x3F800000, B=0x30800000, sub=0 -> 0x3F800000 (diff 30 > 24 clears B in one cycle); latency 4. A=0x7F800000, any B -> 0x7F800000 after 1 cycle.
- Backpressure and reset:
  - Hold i_ready=0 for 5 cycles in DONE -> o_valid=1 and o_result constant; o_ready=0 with i_valid held high.
  - Assert i_rst during ALIGN -> next cycle IDLE, o_valid=0, o_ready=1, o_busy=0.
  - Next transaction then completes correctly.

Source files
------------

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle floating-point add/subtract sequencer: align, add, normalize, truncate.
// Define FPU_SEQ_FAST_ALIGN_EN for single-cycle barrel-shift exponent alignment.
module fpu_addsub_seq #(
    parameter int SIZE     = 32,
    parameter int EXPONENT = 5 + ($clog2(SIZE) - 4) * 3,
    parameter int FRACTION = SIZE - EXPONENT - 1,
    parameter int BIAS     = 2 ** (EXPONENT - 1) - 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [SIZE-1:0] i_A,
    input  logic [SIZE-1:0] i_B,
    input  logic            i_sub,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [SIZE-1:0] o_result,
    output logic            o_busy
);
    // Mantissa layout: {carry, hidden, fraction}
    localparam int MW = FRACTION + 2;
    localparam logic [EXPONENT-1:0] EXP_ONES = EXPONENT'(2 * BIAS + 1);
    localparam logic [EXPONENT-1:0] EXP_ZERO = {EXPONENT{1'b0}};
    localparam logic [EXPONENT-1:0] EXP_ONE  = {{(EXPONENT-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]       MAN_ZERO = {MW{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                sign_a_r, sign_a_nxt_s;
    logic                sign_b_r, sign_b_nxt_s;
    logic [EXPONENT-1:0] exp_a_r, exp_a_nxt_s;
    logic [EXPONENT-1:0] exp_b_r, exp_b_nxt_s;
    logic [MW-1:0]       man_a_r, man_a_nxt_s;
    logic [MW-1:0]       man_b_r, man_b_nxt_s;
    logic [SIZE-1:0]     result_r, result_nxt_s;
    logic                valid_r, ready_r, busy_r;
    logic [EXPONENT-1:0] diff_ab_s, diff_ba_s, exp_inc_s, exp_dec_s;

    // Zero exponent means zero; denormal fractions are flushed.
    function automatic logic [MW-1:0] unpack_man(input logic [SIZE-1:0] word_s);
        logic [MW-1:0] man_s;
        if (word_s[SIZE-2 -: EXPONENT] == EXP_ZERO) begin
            man_s = MAN_ZERO;
        end else begin
            man_s = {1'b0, 1'b1, word_s[FRACTION-1:0]};
        end
        return man_s;
    endfunction

    function automatic logic [SIZE-1:0] pack(input logic sign_s, input logic [EXPONENT-1:0] exp_s,
                                             input logic [FRACTION-1:0] frac_s);
        return {sign_s, exp_s, frac_s};
    endfunction

`ifdef FPU_SEQ_FAST_ALIGN_EN
    localparam logic [EXPONENT-1:0] SHIFT_CAP = EXPONENT'(MW);

    function automatic logic [MW-1:0] align_shift(input logic [MW-1:0] man_s,
                                                  input logic [EXPONENT-1:0] diff_s);
        logic [EXPONENT-1:0] amt_s;
        if (diff_s > SHIFT_CAP) begin
            amt_s = SHIFT_CAP;
        end else begin
            amt_s = diff_s;
        end
        return man_s >> amt_s;
    endfunction
`else
    localparam logic [EXPONENT-1:0] MAX_STEP = EXPONENT'(FRACTION + 1);
`endif

    assign diff_ab_s = exp_a_r - exp_b_r;
    assign diff_ba_s = exp_b_r - exp_a_r;
    assign exp_inc_s = exp_a_r + EXP_ONE;
    assign exp_dec_s = exp_a_r - EXP_ONE;

    assign o_valid  = valid_r;
    assign o_ready  = ready_r;
    assign o_busy   = busy_r;
    assign o_result = result_r;

    // Next-state and datapath update; ADD/NORM reuse the A registers as the working result
    always_comb begin
        state_nxt_s  = state_r;
        sign_a_nxt_s = sign_a_r;
        sign_b_nxt_s = sign_b_r;
        exp_a_nxt_s  = exp_a_r;
        exp_b_nxt_s  = exp_b_r;
        man_a_nxt_s  = man_a_r;
        man_b_nxt_s  = man_b_r;
        result_nxt_s = result_r;
        case (state_r)
            S_IDLE: begin
                if (i_valid && ready_r) begin
                    sign_a_nxt_s = i_A[SIZE-1];
                    sign_b_nxt_s = i_B[SIZE-1] ^ i_sub;
                    exp_a_nxt_s  = i_A[SIZE-2 -: EXPONENT];
                    exp_b_nxt_s  = i_B[SIZE-2 -: EXPONENT];
                    man_a_nxt_s  = unpack_man(i_A);
                    man_b_nxt_s  = unpack_man(i_B);
                    state_nxt_s  = S_ALIGN;
                end else begin
                    state_nxt_s  = S_IDLE;
                end
            end
            S_ALIGN: begin
                if (exp_a_r == EXP_ONES) begin
                    result_nxt_s = pack(sign_a_r, exp_a_r, man_a_r[FRACTION-1:0]);
                    state_nxt_s  = S_DONE;
                end else if (exp_b_r == EXP_ONES) begin
                    result_nxt_s = pack(sign_b_r, exp_b_r, man_b_r[FRACTION-1:0]);
                    state_nxt_s  = S_DONE;
                end else begin
`ifdef FPU_SEQ_FAST_ALIGN_EN
                    if (exp_a_r < exp_b_r) begin
                        man_a_nxt_s = align_shift(man_a_r, diff_ba_s);
                        exp_a_nxt_s = exp_b_r;
                    end else begin
                        man_b_nxt_s = align_shift(man_b_r, diff_ab_s);
                        exp_b_nxt_s = exp_a_r;
                    end
                    state_nxt_s = S_ADD;
`else
                    if (exp_a_r == exp_b_r) begin
                        state_nxt_s = S_ADD;
                    end else if (exp_a_r < exp_b_r) begin
                        if (diff_ba_s > MAX_STEP) begin
                            man_a_nxt_s = MAN_ZERO;
                            exp_a_nxt_s = exp_b_r;
                        end else begin
                            man_a_nxt_s = {1'b0, man_a_r[MW-1:1]};
                            exp_a_nxt_s = exp_inc_s;
                        end
                    end else begin
                        if (diff_ab_s > MAX_STEP) begin
                            man_b_nxt_s = MAN_ZERO;
                            exp_b_nxt_s = exp_a_r;
                        end else begin
                            man_b_nxt_s = {1'b0, man_b_r[MW-1:1]};
                            exp_b_nxt_s = exp_b_r + EXP_ONE;
                        end
                    end
`endif
                end
            end
            S_ADD: begin
                state_nxt_s = S_NORM;
                if (sign_a_r == sign_b_r) begin
                    man_a_nxt_s = man_a_r + man_b_r;
                end else if (man_a_r > man_b_r) begin
                    man_a_nxt_s = man_a_r - man_b_r;
                end else if (man_b_r > man_a_r) begin
                    man_a_nxt_s  = man_b_r - man_a_r;
                    sign_a_nxt_s = sign_b_r;
                end else begin
                    man_a_nxt_s  = MAN_ZERO;
                    sign_a_nxt_s = 1'b0;
                end
            end
            S_NORM: begin
                if (man_a_r == MAN_ZERO) begin
                    result_nxt_s = {SIZE{1'b0}};
                    state_nxt_s  = S_DONE;
                end else if (man_a_r[MW-1]) begin
                    man_a_nxt_s = {1'b0, man_a_r[MW-1:1]};
                    exp_a_nxt_s = exp_inc_s;
                    if (exp_inc_s == EXP_ONES) begin
                        result_nxt_s = pack(sign_a_r, EXP_ONES, {FRACTION{1'b0}});
                        state_nxt_s  = S_DONE;
                    end else begin
                        state_nxt_s  = S_NORM;
                    end
                end else if (!man_a_r[FRACTION]) begin
                    man_a_nxt_s = {man_a_r[MW-2:0], 1'b0};
                    exp_a_nxt_s = exp_dec_s;
                    if (exp_dec_s == EXP_ZERO) begin
                        result_nxt_s = pack(sign_a_r, EXP_ZERO, {FRACTION{1'b0}});
                        state_nxt_s  = S_DONE;
                    end else begin
                        state_nxt_s  = S_NORM;
                    end
                end else begin
                    result_nxt_s = pack(sign_a_r, exp_a_r, man_a_r[FRACTION-1:0]);
                    state_nxt_s  = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= S_IDLE;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            exp_a_r  <= EXP_ZERO;
            exp_b_r  <= EXP_ZERO;
            man_a_r  <= MAN_ZERO;
            man_b_r  <= MAN_ZERO;
            result_r <= {SIZE{1'b0}};
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sign_a_r <= sign_a_nxt_s;
            sign_b_r <= sign_b_nxt_s;
            exp_a_r  <= exp_a_nxt_s;
            exp_b_r  <= exp_b_nxt_s;
            man_a_r  <= man_a_nxt_s;
            man_b_r  <= man_b_nxt_s;
            result_r <= result_nxt_s;
            valid_r  <= (state_nxt_s == S_DONE);
            ready_r  <= (state_nxt_s == S_IDLE);
            busy_r   <= (state_nxt_s != S_IDLE);
        end
    end

endmodule
